// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM states, HTRANS codes and
// the peripheral address map used by both the slave interface and the controller.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WWAIT  = 2'b01,
    ST_SETUP  = 2'b10,
    ST_ACCESS = 2'b11
  } apb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] PERIPH0_BASE = 32'h8000_0000;
  localparam logic [31:0] PERIPH1_BASE = 32'h8400_0000;
  localparam logic [31:0] PERIPH2_BASE = 32'h8800_0000;
  localparam logic [31:0] PERIPH_LIMIT = 32'h8C00_0000;

  function automatic logic in_periph_range(input logic [31:0] addr);
    return (addr >= PERIPH0_BASE) && (addr < PERIPH_LIMIT);
  endfunction

endpackage

// File: rtl/apb_controller.sv
// APB sequencing FSM for the AHB-to-APB bridge: one transfer at a time,
// SETUP/ACCESS phases with PREADY wait states, Hreadyout back to the master.
module apb_controller
  import bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          Hclk,
  input  logic          Hresetn,
  input  logic          valid,
  input  logic [AW-1:0] Haddr,
  input  logic          Hwritereg,
  input  logic [2:0]    tempselx,
  input  logic [DW-1:0] Hwdata,
  input  logic          Pready,
  output logic          Hreadyout,
  output logic [2:0]    Pselx,
  output logic          Penable,
  output logic          Pwrite,
  output logic [AW-1:0] Paddr,
  output logic [DW-1:0] Pwdata
);

  apb_state_e    state_q, state_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [2:0]    cmd_sel_q, cmd_sel_d;
  logic          cmd_write_q, cmd_write_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic          accept;

  always_comb begin
    Hreadyout = 1'b0;
    case (state_q)
      ST_IDLE:   Hreadyout = 1'b1;
      ST_ACCESS: Hreadyout = Pready;
      default:   Hreadyout = 1'b0;
    endcase
  end

  // Acceptance is only possible in IDLE or in the last ACCESS cycle.
  assign accept = valid & Hreadyout;

  always_comb begin
    state_d     = state_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_write_d = cmd_write_q;
    cmd_wdata_d = cmd_wdata_q;

    if (accept) begin
      cmd_addr_d  = Haddr;
      cmd_sel_d   = tempselx;
      cmd_write_d = Hwritereg;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = Hwritereg ? ST_WWAIT : ST_SETUP;
      end
      ST_WWAIT: begin
        cmd_wdata_d = Hwdata;
        state_d     = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (Pready) begin
          if (accept) state_d = Hwritereg ? ST_WWAIT : ST_SETUP;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= ST_IDLE;
      cmd_addr_q  <= '0;
      cmd_sel_q   <= '0;
      cmd_write_q <= 1'b0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_write_q <= cmd_write_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  assign Pselx   = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? cmd_sel_q : 3'b000;
  assign Penable = (state_q == ST_ACCESS);
  assign Pwrite  = cmd_write_q;
  assign Paddr   = cmd_addr_q;
  assign Pwdata  = cmd_wdata_q;

endmodule

// File: tb/tb_apb_controller.sv
// Directed cycle-by-cycle bench for apb_controller: vector table plus an
// asynchronous-reset sequence.
module tb_apb_controller;

  logic        Hclk;
  logic        Hresetn;
  logic        valid;
  logic [31:0] Haddr;
  logic        Hwritereg;
  logic [2:0]  tempselx;
  logic [31:0] Hwdata;
  logic        Pready;
  logic        Hreadyout;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  int unsigned n_tests;
  int unsigned n_fail;

  apb_controller #(.AW(32), .DW(32)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .valid     (valid),
    .Haddr     (Haddr),
    .Hwritereg (Hwritereg),
    .tempselx  (tempselx),
    .Hwdata    (Hwdata),
    .Pready    (Pready),
    .Hreadyout (Hreadyout),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        w;
    logic [2:0]  sel;
    logic [31:0] wd;
    logic        pr;
    logic        e_hr;
    logic [2:0]  e_ps;
    logic        e_pe;
    logic        e_pw;
    logic [31:0] e_pa;
    logic [31:0] e_pwd;
  } vec_t;

  vec_t vecs [30];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic v, input logic [31:0] a, input logic w,
                         input logic [2:0] sel, input logic [31:0] wd, input logic pr,
                         input logic hr, input logic [2:0] ps, input logic pe,
                         input logic pw, input logic [31:0] pa, input logic [31:0] pwd);
    vecs[i] = '{v, a, w, sel, wd, pr, hr, ps, pe, pw, pa, pwd};
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic w,
                       input logic [2:0] sel, input logic [31:0] wd, input logic pr);
    valid = v; Haddr = a; Hwritereg = w; tempselx = sel; Hwdata = wd; Pready = pr;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Hresetn = 1'b0;
    drive(1'b0, '0, 1'b0, 3'b000, '0, 1'b1);

    //        i  v  addr          w  sel     wdata         pr  hr ps      pe pw paddr         pwdata
    // reset/idle
    set_vec( 0, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b000, 0, 0, 32'h0,        32'h0);
    // single read, Pready=1
    set_vec( 1, 1, 32'h80000010, 0, 3'b001, 32'h0,        1,  1, 3'b000, 0, 0, 32'h0,        32'h0);
    set_vec( 2, 0, 32'h0,        0, 3'b000, 32'h0,        1,  0, 3'b001, 0, 0, 32'h80000010, 32'h0);
    set_vec( 3, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b001, 1, 0, 32'h80000010, 32'h0);
    set_vec( 4, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b000, 0, 0, 32'h80000010, 32'h0);
    // single write
    set_vec( 5, 1, 32'h84000004, 1, 3'b010, 32'h0,        1,  1, 3'b000, 0, 0, 32'h80000010, 32'h0);
    set_vec( 6, 0, 32'h0,        0, 3'b000, 32'hDEADBEEF, 1,  0, 3'b000, 0, 1, 32'h84000004, 32'h0);
    set_vec( 7, 0, 32'h0,        0, 3'b000, 32'h0,        1,  0, 3'b010, 0, 1, 32'h84000004, 32'hDEADBEEF);
    set_vec( 8, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b010, 1, 1, 32'h84000004, 32'hDEADBEEF);
    set_vec( 9, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b000, 0, 1, 32'h84000004, 32'hDEADBEEF);
    // read with 3 wait states, valid pulse during wait ignored
    set_vec(10, 1, 32'h88000000, 0, 3'b100, 32'h0,        1,  1, 3'b000, 0, 1, 32'h84000004, 32'hDEADBEEF);
    set_vec(11, 0, 32'h0,        0, 3'b000, 32'h0,        0,  0, 3'b100, 0, 0, 32'h88000000, 32'hDEADBEEF);
    set_vec(12, 0, 32'h0,        0, 3'b000, 32'h0,        0,  0, 3'b100, 1, 0, 32'h88000000, 32'hDEADBEEF);
    set_vec(13, 1, 32'h80000044, 1, 3'b001, 32'h0,        0,  0, 3'b100, 1, 0, 32'h88000000, 32'hDEADBEEF);
    set_vec(14, 0, 32'h0,        0, 3'b000, 32'h0,        0,  0, 3'b100, 1, 0, 32'h88000000, 32'hDEADBEEF);
    set_vec(15, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b100, 1, 0, 32'h88000000, 32'hDEADBEEF);
    set_vec(16, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b000, 0, 0, 32'h88000000, 32'hDEADBEEF);
    // back-to-back read then write
    set_vec(17, 1, 32'h80000000, 0, 3'b001, 32'h0,        1,  1, 3'b000, 0, 0, 32'h88000000, 32'hDEADBEEF);
    set_vec(18, 0, 32'h0,        0, 3'b000, 32'h0,        1,  0, 3'b001, 0, 0, 32'h80000000, 32'hDEADBEEF);
    set_vec(19, 1, 32'h80000008, 1, 3'b001, 32'h0,        1,  1, 3'b001, 1, 0, 32'h80000000, 32'hDEADBEEF);
    set_vec(20, 0, 32'h0,        0, 3'b000, 32'h12345678, 1,  0, 3'b000, 0, 1, 32'h80000008, 32'hDEADBEEF);
    set_vec(21, 0, 32'h0,        0, 3'b000, 32'h0,        1,  0, 3'b001, 0, 1, 32'h80000008, 32'h12345678);
    set_vec(22, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b001, 1, 1, 32'h80000008, 32'h12345678);
    set_vec(23, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b000, 0, 1, 32'h80000008, 32'h12345678);
    // back-to-back reads: select goes straight from one SETUP to the next
    set_vec(24, 1, 32'h80000020, 0, 3'b010, 32'h0,        1,  1, 3'b000, 0, 1, 32'h80000008, 32'h12345678);
    set_vec(25, 0, 32'h0,        0, 3'b000, 32'h0,        1,  0, 3'b010, 0, 0, 32'h80000020, 32'h12345678);
    set_vec(26, 1, 32'h80000030, 0, 3'b100, 32'h0,        1,  1, 3'b010, 1, 0, 32'h80000020, 32'h12345678);
    set_vec(27, 0, 32'h0,        0, 3'b000, 32'h0,        1,  0, 3'b100, 0, 0, 32'h80000030, 32'h12345678);
    set_vec(28, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b100, 1, 0, 32'h80000030, 32'h12345678);
    set_vec(29, 0, 32'h0,        0, 3'b000, 32'h0,        1,  1, 3'b000, 0, 0, 32'h80000030, 32'h12345678);

    repeat (2) @(negedge Hclk);
    Hresetn = 1'b1;

    // One row per cycle: drive after the falling edge, check before the rising edge.
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge Hclk);
      drive(vecs[i].v, vecs[i].a, vecs[i].w, vecs[i].sel, vecs[i].wd, vecs[i].pr);
      #1;
      check("hreadyout", i, {31'b0, Hreadyout}, {31'b0, vecs[i].e_hr});
      check("pselx",     i, {29'b0, Pselx},     {29'b0, vecs[i].e_ps});
      check("penable",   i, {31'b0, Penable},   {31'b0, vecs[i].e_pe});
      check("pwrite",    i, {31'b0, Pwrite},    {31'b0, vecs[i].e_pw});
      check("paddr",     i, Paddr,              vecs[i].e_pa);
      check("pwdata",    i, Pwdata,             vecs[i].e_pwd);
    end

    // Write to 0x8400_0004 stalled in ACCESS, then asynchronous reset mid-cycle.
    @(negedge Hclk); drive(1'b1, 32'h84000004, 1'b1, 3'b010, 32'h0, 1'b0);
    @(negedge Hclk); drive(1'b0, 32'h0, 1'b0, 3'b000, 32'hCAFEF00D, 1'b0);
    @(negedge Hclk); drive(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0);
    @(negedge Hclk); #1;
    check("rst_pre_penable", 100, {31'b0, Penable},   32'h1);
    check("rst_pre_hready",  100, {31'b0, Hreadyout}, 32'h0);
    check("rst_pre_pwdata",  100, Pwdata,             32'hCAFEF00D);
    #1 Hresetn = 1'b0;
    #1;
    check("rst_pselx",   101, {29'b0, Pselx},     32'h0);
    check("rst_penable", 101, {31'b0, Penable},   32'h0);
    check("rst_paddr",   101, Paddr,              32'h0);
    check("rst_pwdata",  101, Pwdata,             32'h0);
    check("rst_pwrite",  101, {31'b0, Pwrite},    32'h0);
    check("rst_hready",  101, {31'b0, Hreadyout}, 32'h1);

    @(negedge Hclk); Hresetn = 1'b1; drive(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1);
    @(negedge Hclk); #1;
    check("post_idle_pselx", 102, {29'b0, Pselx},     32'h0);
    check("post_idle_hready", 102, {31'b0, Hreadyout}, 32'h1);
    drive(1'b1, 32'h80000040, 1'b0, 3'b001, 32'h0, 1'b1);
    @(negedge Hclk); drive(1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1); #1;
    check("post_setup_pselx",   103, {29'b0, Pselx},     32'h1);
    check("post_setup_penable", 103, {31'b0, Penable},   32'h0);
    check("post_setup_paddr",   103, Paddr,              32'h80000040);
    check("post_setup_hready",  103, {31'b0, Hreadyout}, 32'h0);
    @(negedge Hclk); #1;
    check("post_access_penable", 104, {31'b0, Penable},   32'h1);
    check("post_access_hready",  104, {31'b0, Hreadyout}, 32'h1);
    @(negedge Hclk); #1;
    check("post_done_pselx", 105, {29'b0, Pselx}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
